memory_arbiter: RTL and testbench

Two-client arbiter that lets the instruction cache and the data cache share a single main-memory port of 128-bit blocks. It sits between the caches' miss ports and one memory model, replacing the separate instruction/data memory instances in the CPU top level. It serialises block reads and write-backs, grants round-robin when both caches miss together, and returns per-client busywait and read data using the codebase's busywait handshake.

---
 rtl/memory_arbiter.sv | 102 ++++++++++
 tb/tb_memory_arbiter.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing one 128-bit block memory port between the
// instruction cache (reads) and the data cache (reads and write-backs).
module memory_arbiter #(
    parameter int ADDR_WIDTH  = 28,
    parameter int BLOCK_WIDTH = 128
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   I_MEM_READ,
    input  logic [ADDR_WIDTH-1:0]  I_MEM_ADDRESS,
    output logic [BLOCK_WIDTH-1:0] I_MEM_READDATA,
    output logic                   I_MEM_BUSYWAIT,
    input  logic                   D_MEM_READ,
    input  logic                   D_MEM_WRITE,
    input  logic [ADDR_WIDTH-1:0]  D_MEM_ADDRESS,
    input  logic [BLOCK_WIDTH-1:0] D_MEM_WRITEDATA,
    output logic [BLOCK_WIDTH-1:0] D_MEM_READDATA,
    output logic                   D_MEM_BUSYWAIT,
    output logic                   MEM_READ,
    output logic                   MEM_WRITE,
    output logic [ADDR_WIDTH-1:0]  MEM_ADDRESS,
    output logic [BLOCK_WIDTH-1:0] MEM_WRITEDATA,
    input  logic [BLOCK_WIDTH-1:0] MEM_READDATA,
    input  logic                   MEM_BUSYWAIT
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    typedef enum logic {GRANT_I = 1'b0, GRANT_D = 1'b1} client_t;

    state_t  state;
    client_t grant;
    client_t last_grant;

    logic i_req;
    logic d_req;
    logic pick_d;

    assign i_req = I_MEM_READ;
    assign d_req = D_MEM_READ | D_MEM_WRITE;

    // On a tie the client that was not served last wins.
    assign pick_d = d_req & (~i_req | (last_grant == GRANT_I));

    assign I_MEM_BUSYWAIT = i_req & ~((state == RESP) & (grant == GRANT_I));
    assign D_MEM_BUSYWAIT = d_req & ~((state == RESP) & (grant == GRANT_D));

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values and simulation matches the synthesized flops.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state          <= IDLE;
            grant          <= GRANT_I;
            last_grant     <= GRANT_I;
            MEM_READ       <= 1'b0;
            MEM_WRITE      <= 1'b0;
            MEM_ADDRESS    <= '0;
            MEM_WRITEDATA  <= '0;
            I_MEM_READDATA <= '0;
            D_MEM_READDATA <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_req | d_req) begin
                        state <= ISSUE;
                        if (pick_d) begin
                            grant       <= GRANT_D;
                            last_grant  <= GRANT_D;
                            MEM_ADDRESS <= D_MEM_ADDRESS;
                            // A write-back wins if both D strobes are high.
                            if (D_MEM_WRITE) begin
                                MEM_WRITE     <= 1'b1;
                                MEM_WRITEDATA <= D_MEM_WRITEDATA;
                            end else begin
                                MEM_READ <= 1'b1;
                            end
                        end else begin
                            grant       <= GRANT_I;
                            last_grant  <= GRANT_I;
                            MEM_ADDRESS <= I_MEM_ADDRESS;
                            MEM_READ    <= 1'b1;
                        end
                    end
                end
                ISSUE: state <= WAIT;
                WAIT: begin
                    if (!MEM_BUSYWAIT) begin
                        if (MEM_READ) begin
                            if (grant == GRANT_D) D_MEM_READDATA <= MEM_READDATA;
                            else                  I_MEM_READDATA <= MEM_READDATA;
                        end
                        MEM_READ  <= 1'b0;
                        MEM_WRITE <= 1'b0;
                        state     <= RESP;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: directed vector table, hand-written
// corner sequences, and a randomized run against a transaction-level model.
module tb_memory_arbiter;

    localparam logic [127:0] DATA_A = 128'hAAAAAAAA_AAAAAAAA_AAAAAAAA_AAAAAA01;
    localparam logic [127:0] DATA_B = 128'hBBBBBBBB_BBBBBBBB_BBBBBBBB_BBBBBB02;
    localparam logic [127:0] WDATA1 = 128'h12340000_00000000_00000000_00005678;
    localparam logic [127:0] WDATA2 = 128'hFEEDFACE_01234567_89ABCDEF_0000CAFE;

    logic         clk;
    logic         reset;
    logic         i_mem_read;
    logic [27:0]  i_mem_address;
    logic [127:0] i_mem_readdata;
    logic         i_mem_busywait;
    logic         d_mem_read;
    logic         d_mem_write;
    logic [27:0]  d_mem_address;
    logic [127:0] d_mem_writedata;
    logic [127:0] d_mem_readdata;
    logic         d_mem_busywait;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_address;
    logic [127:0] mem_writedata;
    logic [127:0] mem_readdata;
    logic         mem_busywait;

    int passed = 0;
    int total  = 0;

    memory_arbiter #(.ADDR_WIDTH(28), .BLOCK_WIDTH(128)) dut (
        .CLK            (clk),
        .RESET          (reset),
        .I_MEM_READ     (i_mem_read),
        .I_MEM_ADDRESS  (i_mem_address),
        .I_MEM_READDATA (i_mem_readdata),
        .I_MEM_BUSYWAIT (i_mem_busywait),
        .D_MEM_READ     (d_mem_read),
        .D_MEM_WRITE    (d_mem_write),
        .D_MEM_ADDRESS  (d_mem_address),
        .D_MEM_WRITEDATA(d_mem_writedata),
        .D_MEM_READDATA (d_mem_readdata),
        .D_MEM_BUSYWAIT (d_mem_busywait),
        .MEM_READ       (mem_read),
        .MEM_WRITE      (mem_write),
        .MEM_ADDRESS    (mem_address),
        .MEM_WRITEDATA  (mem_writedata),
        .MEM_READDATA   (mem_readdata),
        .MEM_BUSYWAIT   (mem_busywait)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] mem_init_val(input int i);
        logic [31:0] w;
        w = 32'hC0DE_0000 + 32'(i);
        case (i)
            1:       return DATA_A;
            2:       return DATA_B;
            default: return {w, w, w, w};
        endcase
    endfunction

    // Main memory: 16 blocks selected by address bits [7:4]; busy for lat_cfg
    // cycles after a request appears.
    logic [127:0] main_mem [16];
    bit           mem_loaded = 1'b0;
    int           lat_cfg    = 0;
    int           busy_cnt   = 0;

    assign mem_busywait = (mem_read | mem_write) && (busy_cnt < lat_cfg);
    assign mem_readdata = main_mem[mem_address[7:4]];

    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 16; i++) main_mem[i] <= mem_init_val(i);
            mem_loaded <= 1'b1;
        end else if (mem_write && !mem_busywait) begin
            main_mem[mem_address[7:4]] <= mem_writedata;
        end
        busy_cnt <= (mem_read | mem_write) ? busy_cnt + 1 : 0;
    end

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic drop_requests();
        i_mem_read  = 1'b0;
        d_mem_read  = 1'b0;
        d_mem_write = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        drop_requests();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct {
        string        name;
        bit           i_rd;
        bit           d_rd;
        bit           d_wr;
        logic [27:0]  i_addr;
        logic [27:0]  d_addr;
        logic [127:0] wdata;
        int           lat;
        bit           exp_dgrant;
        logic [27:0]  exp_addr;
        bit           exp_wr;
        logic [127:0] exp_i_rdata;
        logic [127:0] exp_d_rdata;
    } vec_t;

    vec_t vecs[7];

    // One complete transaction from IDLE: op and address in cycle 1, exact RESP
    // cycle, cleared memory strobes in RESP and both readdata holders.
    task automatic run_vec(input vec_t v);
        int   cyc;
        int   resp_cyc;
        bit   done;
        logic g_bw;
        logic o_bw;
        lat_cfg         = v.lat;
        i_mem_read      = v.i_rd;
        i_mem_address   = v.i_addr;
        d_mem_read      = v.d_rd;
        d_mem_write     = v.d_wr;
        d_mem_address   = v.d_addr;
        d_mem_writedata = v.wdata;
        resp_cyc = (v.lat < 1) ? 3 : v.lat + 2;
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            g_bw = v.exp_dgrant ? d_mem_busywait : i_mem_busywait;
            o_bw = v.exp_dgrant ? i_mem_busywait : d_mem_busywait;
            if (cyc == 1) begin
                check({v.name, "/op"}, 128'({mem_read, mem_write}), 128'(v.exp_wr ? 2'b01 : 2'b10));
                check({v.name, "/addr"}, 128'(mem_address), 128'(v.exp_addr));
                if (v.exp_wr) check({v.name, "/wdata"}, mem_writedata, v.wdata);
                if (v.i_rd && (v.d_rd || v.d_wr)) check({v.name, "/loser_busy"}, 128'(o_bw), 128'(1'b1));
            end
            if (!g_bw) begin
                done = 1'b1;
                check({v.name, "/resp_cycle"}, 128'(cyc), 128'(resp_cyc));
                check({v.name, "/resp_strobes"}, 128'({mem_read, mem_write}), 128'(2'b00));
                check({v.name, "/i_rdata"}, i_mem_readdata, v.exp_i_rdata);
                check({v.name, "/d_rdata"}, d_mem_readdata, v.exp_d_rdata);
            end
        end
        check({v.name, "/completed"}, 128'(done), 128'(1'b1));
        drop_requests();
        @(negedge clk);
    endtask

    logic [127:0] ref_mem [16];

    initial begin
        vec_t  tv;
        bit    prev_op;
        bit    op;
        int    n_starts;
        int    n_done;
        int    i_done;
        int    d_done;
        int    d_resp_cyc;
        int    start_cyc [4];
        logic  [3:0] order;
        bit    i_ok;
        bit    done;
        bit    model_last_d;
        bit    cur_d;
        bit    in_txn;
        bit    pick_d;
        bit    d_pending;
        bit    i_just_done;
        bit    d_just_done;
        logic  [27:0] exp_addr;

        // name, i_rd, d_rd, d_wr, i_addr, d_addr, wdata, lat,
        // exp_dgrant, exp_addr, exp_wr, exp_i_rdata, exp_d_rdata
        vecs[0] = '{"i_rd_0x10",   1, 0, 0, 28'h10, 28'h00, 128'h0,  5, 0, 28'h10, 0, DATA_A, 128'h0};
        vecs[1] = '{"d_wb_0x30",   0, 0, 1, 28'h00, 28'h30, WDATA1,  2, 1, 28'h30, 1, DATA_A, 128'h0};
        vecs[2] = '{"tie_last_d",  1, 1, 0, 28'h20, 28'h30, 128'h0,  1, 0, 28'h20, 0, DATA_B, 128'h0};
        vecs[3] = '{"tie_last_i",  1, 1, 0, 28'h10, 28'h30, 128'h0,  0, 1, 28'h30, 0, DATA_B, WDATA1};
        vecs[4] = '{"d_rd_wr_0x40",0, 1, 1, 28'h00, 28'h40, WDATA2,  3, 1, 28'h40, 1, DATA_B, WDATA1};
        vecs[5] = '{"d_rd_0x40",   0, 1, 0, 28'h00, 28'h40, 128'h0,  1, 1, 28'h40, 0, DATA_B, WDATA2};
        vecs[6] = '{"i_rd_0x40",   1, 0, 0, 28'h40, 28'h00, 128'h0,  2, 0, 28'h40, 0, WDATA2, WDATA2};

        for (int i = 0; i < 16; i++) ref_mem[i] = mem_init_val(i);

        reset           = 1'b1;
        i_mem_read      = 1'b0;
        i_mem_address   = '0;
        d_mem_read      = 1'b0;
        d_mem_write     = 1'b0;
        d_mem_address   = '0;
        d_mem_writedata = '0;

        // Reset state
        do_reset();
        check("reset/strobes", 128'({mem_read, mem_write}), 128'(2'b00));
        check("reset/addr", 128'(mem_address), 128'(28'h0));
        check("reset/wdata", mem_writedata, 128'h0);
        check("reset/i_rdata", i_mem_readdata, 128'h0);
        check("reset/d_rdata", d_mem_readdata, 128'h0);
        check("reset/busywaits", 128'({i_mem_busywait, d_mem_busywait}), 128'(2'b00));

        // Directed vector table
        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Both clients held pending after reset: D, I, D, I with one IDLE gap
        do_reset();
        i_mem_read    = 1'b1;
        i_mem_address = 28'h10;
        d_mem_read    = 1'b1;
        d_mem_address = 28'h20;
        lat_cfg       = 2;
        prev_op  = 1'b0;
        n_starts = 0;
        i_done   = 0;
        d_done   = 0;
        d_resp_cyc = 0;
        order    = 4'b0;
        i_ok     = 1'b1;
        for (int c = 0; c < 200 && (i_done + d_done) < 4; c++) begin
            @(negedge clk);
            op = mem_read | mem_write;
            if (op && !prev_op && n_starts < 4) begin
                order = {order[2:0], (mem_address == 28'h20)};
                start_cyc[n_starts] = c;
                n_starts++;
            end
            if (n_starts == 1 && d_done == 0 && !i_mem_busywait) i_ok = 1'b0;
            if (!d_mem_busywait) begin
                if (d_done == 0) begin
                    d_resp_cyc = c;
                    check("rr/d_first_rdata", d_mem_readdata, DATA_B);
                end
                d_done++;
            end
            if (!i_mem_busywait) begin
                if (i_done == 0) check("rr/i_first_rdata", i_mem_readdata, DATA_A);
                i_done++;
            end
            prev_op = op;
        end
        drop_requests();
        check("rr/starts", 128'(n_starts), 128'(4));
        check("rr/order_DIDI", 128'(order), 128'(4'b1010));
        check("rr/i_busy_during_d", 128'(i_ok), 128'(1'b1));
        check("rr/one_idle_gap", 128'(start_cyc[1]), 128'(d_resp_cyc + 2));
        @(negedge clk);
        @(negedge clk);

        // Reset in WAIT abandons an I read
        i_mem_read    = 1'b1;
        i_mem_address = 28'h30;
        lat_cfg       = 10;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("rst_wait/read_active", 128'(mem_read), 128'(1'b1));
        reset = 1'b1;
        drop_requests();
        @(negedge clk);
        check("rst_wait/read_dropped", 128'(mem_read), 128'(1'b0));
        check("rst_wait/i_rdata", i_mem_readdata, 128'h0);
        check("rst_wait/d_rdata", d_mem_readdata, 128'h0);
        reset = 1'b0;
        tv = '{"post_rst_tie", 1, 1, 0, 28'h20, 28'h10, 128'h0, 1, 1, 28'h10, 0, 128'h0, DATA_A};
        run_vec(tv);

        // Granted D read withdrawn after ISSUE; pending I served afterwards
        d_mem_read    = 1'b1;
        d_mem_address = 28'h30;
        lat_cfg       = 4;
        @(negedge clk);
        @(negedge clk);
        check("withdraw/d_read_issued", 128'({mem_read, mem_address}), 128'({1'b1, 28'h30}));
        i_mem_read    = 1'b1;
        i_mem_address = 28'h20;
        @(negedge clk);
        d_mem_read = 1'b0;
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (!mem_read) done = 1'b1;
        end
        check("withdraw/read_finished", 128'(done), 128'(1'b1));
        check("withdraw/d_rdata", d_mem_readdata, WDATA1);
        check("withdraw/i_still_busy", 128'(i_mem_busywait), 128'(1'b1));
        @(negedge clk);
        @(negedge clk);
        check("withdraw/i_granted", 128'({mem_read, mem_address}), 128'({1'b1, 28'h20}));
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (!i_mem_busywait) done = 1'b1;
        end
        check("withdraw/i_done", 128'(done), 128'(1'b1));
        check("withdraw/i_rdata", i_mem_readdata, DATA_B);
        drop_requests();

        // Randomized traffic against a transaction-level model on blocks 5..12
        do_reset();
        model_last_d = 1'b0;
        cur_d        = 1'b0;
        in_txn       = 1'b0;
        prev_op      = 1'b0;
        n_done       = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            op = mem_read | mem_write;
            d_pending = d_mem_read | d_mem_write;
            i_just_done = 1'b0;
            d_just_done = 1'b0;
            if (op && !prev_op) begin
                check("rand/start_has_req", 128'(i_mem_read | d_pending), 128'(1'b1));
                pick_d   = d_pending && (!i_mem_read || !model_last_d);
                exp_addr = pick_d ? d_mem_address : i_mem_address;
                check("rand/addr", 128'(mem_address), 128'(exp_addr));
                check("rand/op", 128'({mem_read, mem_write}),
                      128'((pick_d && d_mem_write) ? 2'b01 : 2'b10));
                if (pick_d && d_mem_write) check("rand/wdata", mem_writedata, d_mem_writedata);
                model_last_d = pick_d;
                cur_d        = pick_d;
                in_txn       = 1'b1;
            end
            if (i_mem_read && !i_mem_busywait) begin
                check("rand/i_owner", 128'({in_txn, cur_d}), 128'(2'b10));
                check("rand/i_rdata", i_mem_readdata, ref_mem[i_mem_address[7:4]]);
                i_mem_read  = 1'b0;
                i_just_done = 1'b1;
                in_txn      = 1'b0;
                n_done++;
            end
            if (d_pending && !d_mem_busywait) begin
                check("rand/d_owner", 128'({in_txn, cur_d}), 128'(2'b11));
                if (d_mem_write) ref_mem[d_mem_address[7:4]] = d_mem_writedata;
                else check("rand/d_rdata", d_mem_readdata, ref_mem[d_mem_address[7:4]]);
                d_mem_read  = 1'b0;
                d_mem_write = 1'b0;
                d_just_done = 1'b1;
                in_txn      = 1'b0;
                n_done++;
            end
            prev_op = op;
            if (!op) lat_cfg = $urandom_range(0, 3);
            if (!i_mem_read && !i_just_done && $urandom_range(0, 1) == 1) begin
                i_mem_read    = 1'b1;
                i_mem_address = {20'h0, 4'(5 + $urandom_range(0, 7)), 4'h0};
            end
            if (!(d_mem_read | d_mem_write) && !d_just_done && $urandom_range(0, 1) == 1) begin
                d_mem_write     = ($urandom_range(0, 1) == 1);
                d_mem_read      = !d_mem_write;
                d_mem_address   = {20'h0, 4'(5 + $urandom_range(0, 7)), 4'h0};
                d_mem_writedata = {$urandom, $urandom, $urandom, $urandom};
            end
        end
        drop_requests();
        check("rand/progress", 128'(n_done >= 100), 128'(1'b1));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
